// File: rtl/key_filter_pkg.sv
// Shared definitions for the multi-channel key debouncer: FSM encoding and
// the counter width helper.
package key_filter_pkg;

  // Per-channel filter FSM. The encoding is fixed so that state dumps read the
  // same across all tools.
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StFiltDn = 2'd1,
    StDown   = 2'd2,
    StFiltUp = 2'd3
  } key_fsm_e;

  // Width needed to hold any of the three cycle counts without wrapping.
  function automatic int unsigned cnt_width(input int unsigned debounce_cyc,
                                            input int unsigned long_cyc,
                                            input int unsigned repeat_cyc);
    int unsigned max_cyc;
    max_cyc = debounce_cyc;
    if (long_cyc > max_cyc) max_cyc = long_cyc;
    if (repeat_cyc > max_cyc) max_cyc = repeat_cyc;
    return $clog2(max_cyc + 1);
  endfunction

endpackage

// File: rtl/key_filter_ch.sv
// One key channel: 2-FF synchroniser, press/release filter FSM, debounce
// counter and hold counter for long-press / auto-repeat detection.
module key_filter_ch
  import key_filter_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 1_000_000,
  parameter int unsigned LONG_CYC     = 50_000_000,
  parameter int unsigned REPEAT_CYC   = 0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_ni,
  output logic key_press_o,
  output logic key_release_o,
  output logic key_long_o,
  output logic key_state_o
);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYC, LONG_CYC, REPEAT_CYC);

  localparam logic [CNT_W-1:0] DebLast  = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] LongLast = CNT_W'(LONG_CYC - 1);
  // Reloading here makes the counter climb back to LongLast in REPEAT_CYC cycles.
  localparam logic [CNT_W-1:0] Reload   = CNT_W'(LONG_CYC - REPEAT_CYC);

  logic       sync1_q, sync2_q;
  key_fsm_e   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic       press_q, press_d;
  logic       release_q, release_d;
  logic       long_q, long_d;
  logic       level_q, level_d;
  logic       s;

  assign s = sync2_q;

  // Next-state logic for the filter FSM, both counters and the event pulses.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    level_d   = level_q;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!s) state_d = StFiltDn;
      end

      StFiltDn: begin
        if (s) begin
          // Bounce back to released: drop the attempt silently.
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == DebLast) begin
          state_d = StDown;
          cnt_d   = '0;
          hold_d  = '0;
          press_d = 1'b1;
          level_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      StDown: begin
        cnt_d = '0;
        if (s) begin
          // Hold count is frozen while the release is being filtered.
          state_d = StFiltUp;
        end else if (hold_q == LongLast) begin
          if (REPEAT_CYC != 0) begin
            hold_d = Reload;
            long_d = (Reload == LongLast);
          end
        end else begin
          hold_d = hold_q + CNT_W'(1);
          long_d = (hold_d == LongLast);
        end
      end

      StFiltUp: begin
        if (!s) begin
          // Release glitch: resume the hold count where it stopped.
          state_d = StDown;
          cnt_d   = '0;
        end else if (cnt_q == DebLast) begin
          state_d   = StIdle;
          cnt_d     = '0;
          hold_d    = '0;
          release_d = 1'b1;
          level_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        hold_d  = '0;
      end
    endcase
  end

  // Synchroniser, FSM state, counters and registered outputs; sync reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      state_q   <= StIdle;
      cnt_q     <= '0;
      hold_q    <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      level_q   <= 1'b1;
    end else begin
      sync1_q   <= key_ni;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      level_q   <= level_d;
    end
  end

  assign key_press_o   = press_q;
  assign key_release_o = release_q;
  assign key_long_o    = long_q;
  assign key_state_o   = level_q;

endmodule

// File: rtl/key_filter_multi.sv
// Debouncer for NUM_KEYS active-low push-buttons: one independent filter
// channel per key plus a combined press/release event flag.
module key_filter_multi
  import key_filter_pkg::*;
#(
  parameter int unsigned NUM_KEYS     = 4,
  parameter int unsigned DEBOUNCE_CYC = 1_000_000,
  parameter int unsigned LONG_CYC     = 50_000_000,
  parameter int unsigned REPEAT_CYC   = 0
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [NUM_KEYS-1:0] key,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long,
  output logic [NUM_KEYS-1:0] key_state,
  output logic                key_flag
);

  // Counters assume at least two cycles of filtering and a reload that fits.
  if (DEBOUNCE_CYC < 2 || LONG_CYC < 2 || REPEAT_CYC > LONG_CYC) begin : g_bad_params
    $error("key_filter_multi: illegal DEBOUNCE_CYC/LONG_CYC/REPEAT_CYC combination");
  end

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_filter_ch #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .LONG_CYC     (LONG_CYC),
      .REPEAT_CYC   (REPEAT_CYC)
    ) u_ch (
      .clk_i         (Clk),
      .rst_i         (Reset),
      .key_ni        (key[i]),
      .key_press_o   (key_press[i]),
      .key_release_o (key_release[i]),
      .key_long_o    (key_long[i]),
      .key_state_o   (key_state[i])
    );
  end

  // Combinational so user logic sees the flag in the same cycle as the pulses.
  assign key_flag = |(key_press | key_release);

endmodule

// File: tb/tb_key_filter_multi.sv
// Bench for key_filter_multi: two instances (auto-repeat off and on) share one
// stimulus stream and are checked every cycle against a behavioural model,
// plus directed scenarios with hand-computed timing.
module tb_key_filter_multi;

  localparam int NK = 4;
  localparam int D  = 8;
  localparam int L  = 32;
  localparam int R1 = 8;

  logic          Clk = 1'b0;
  logic          Reset;
  logic [NK-1:0] key;

  logic [NK-1:0] press0, rel0, long0, state0;
  logic          flag0;
  logic [NK-1:0] press1, rel1, long1, state1;
  logic          flag1;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 Clk = ~Clk;

  key_filter_multi #(
    .NUM_KEYS     (NK),
    .DEBOUNCE_CYC (D),
    .LONG_CYC     (L),
    .REPEAT_CYC   (0)
  ) u_dut0 (
    .Clk         (Clk),
    .Reset       (Reset),
    .key         (key),
    .key_press   (press0),
    .key_release (rel0),
    .key_long    (long0),
    .key_state   (state0),
    .key_flag    (flag0)
  );

  key_filter_multi #(
    .NUM_KEYS     (NK),
    .DEBOUNCE_CYC (D),
    .LONG_CYC     (L),
    .REPEAT_CYC   (R1)
  ) u_dut1 (
    .Clk         (Clk),
    .Reset       (Reset),
    .key         (key),
    .key_press   (press1),
    .key_release (rel1),
    .key_long    (long1),
    .key_state   (state1),
    .key_flag    (flag1)
  );

  task automatic cmp(input string name, input logic [NK-1:0] got, input logic [NK-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, got, exp);
    end
  endtask

  // Behavioural model: the debounced level flips once the synchronised input
  // has disagreed with it for D+1 consecutive edges; h counts edges spent
  // steadily pressed, and long pulses fall at h = L-1 (+ multiples of R).
  bit            m_s1 [NK];
  bit            m_s2 [NK];
  bit            m_lvl[NK];
  int            m_run[NK];
  int            m_h  [NK];
  bit            m_cur;
  bit            m_steady;
  logic [NK-1:0] e_press, e_rel, e_long0, e_long1, e_state;

  always @(posedge Clk) begin
    for (int k = 0; k < NK; k++) begin
      e_press[k] = 1'b0;
      e_rel[k]   = 1'b0;
      e_long0[k] = 1'b0;
      e_long1[k] = 1'b0;
      if (Reset) begin
        m_s1[k]  = 1'b1;
        m_s2[k]  = 1'b1;
        m_lvl[k] = 1'b1;
        m_run[k] = 0;
        m_h[k]   = 0;
      end else begin
        m_cur    = m_s2[k];
        m_steady = (m_lvl[k] == 1'b0) && (m_run[k] == 0);
        if (m_cur != m_lvl[k]) begin
          m_run[k]++;
          if (m_run[k] == D + 1) begin
            m_lvl[k] = m_cur;
            m_run[k] = 0;
            m_h[k]   = 0;
            if (m_cur == 1'b0) e_press[k] = 1'b1;
            else               e_rel[k]   = 1'b1;
          end
        end else begin
          m_run[k] = 0;
          if (m_steady) begin
            m_h[k]++;
            e_long0[k] = (m_h[k] == L - 1);
            e_long1[k] = (m_h[k] >= L - 1) && (((m_h[k] - (L - 1)) % R1) == 0);
          end
        end
        m_s2[k] = m_s1[k];
        m_s1[k] = key[k];
      end
      e_state[k] = m_lvl[k];
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge Clk) begin
    if (chk_en) begin
      cmp("press0", press0, e_press);
      cmp("release0", rel0, e_rel);
      cmp("long0", long0, e_long0);
      cmp("state0", state0, e_state);
      cmp("flag0", {3'b000, flag0}, {3'b000, |(e_press | e_rel)});
      cmp("press1", press1, e_press);
      cmp("release1", rel1, e_rel);
      cmp("long1", long1, e_long1);
      cmp("state1", state1, e_state);
      cmp("flag1", {3'b000, flag1}, {3'b000, |(e_press | e_rel)});
    end
  end

  int rem[NK];

  initial begin
    Reset = 1'b1;
    key   = '1;
    repeat (3) @(negedge Clk);
    chk_en = 1'b1;
    cmp("lit_reset_state", state0, 4'hF);
    cmp("lit_reset_press", press0 | rel0 | long0, 4'h0);
    Reset = 1'b0;
    repeat (5) @(negedge Clk);

    // Clean press on key 0: pulse visible after the 10th edge past sampling.
    key[0] = 1'b0;
    repeat (10) @(negedge Clk);
    cmp("lit_press0_early", press0, 4'h0);
    @(negedge Clk);
    cmp("lit_press0", press0, 4'h1);
    cmp("lit_flag_press0", {3'b000, flag0}, 4'h1);
    cmp("lit_state0_low", state0, 4'hE);
    @(negedge Clk);
    cmp("lit_press0_once", press0, 4'h0);
    repeat (40) @(negedge Clk);
    key[0] = 1'b1;
    repeat (20) @(negedge Clk);

    // Bounce on key 1: timing restarts from the last falling edge.
    key[1] = 1'b0;
    repeat (5) @(negedge Clk);
    key[1] = 1'b1;
    repeat (3) @(negedge Clk);
    key[1] = 1'b0;
    repeat (10) @(negedge Clk);
    cmp("lit_bounce_early", press0, 4'h0);
    @(negedge Clk);
    cmp("lit_bounce_press", press0, 4'h2);
    repeat (10) @(negedge Clk);

    // Release glitch on key 1 must not produce any event.
    key[1] = 1'b1;
    repeat (4) @(negedge Clk);
    key[1] = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge Clk);
      cmp("lit_glitch_events", (press0 | rel0) & 4'h2, 4'h0);
    end
    cmp("lit_glitch_state", state0, 4'hD);
    key[1] = 1'b1;
    repeat (11) @(negedge Clk);
    cmp("lit_release1", rel0, 4'h2);
    cmp("lit_release1_state", state0, 4'hF);
    repeat (10) @(negedge Clk);

    // Long press on key 2: first pulse at press+31, repeats every 8 on dut1.
    key[2] = 1'b0;
    repeat (11) @(negedge Clk);
    cmp("lit_long_press", press1, 4'h4);
    repeat (31) @(negedge Clk);
    cmp("lit_long0_first", long0, 4'h4);
    cmp("lit_long1_first", long1, 4'h4);
    repeat (8) @(negedge Clk);
    cmp("lit_long0_no_repeat", long0, 4'h0);
    cmp("lit_long1_repeat", long1, 4'h4);
    repeat (30) @(negedge Clk);
    key[2] = 1'b1;
    repeat (20) @(negedge Clk);

    // All keys fall together.
    key = 4'h0;
    repeat (10) @(negedge Clk);
    cmp("lit_simul_early", press0, 4'h0);
    @(negedge Clk);
    cmp("lit_simul_press0", press0, 4'hF);
    cmp("lit_simul_press1", press1, 4'hF);
    cmp("lit_simul_flag", {3'b000, flag0}, 4'h1);
    @(negedge Clk);
    cmp("lit_simul_flag_off", {3'b000, flag0}, 4'h0);
    key = 4'hF;
    repeat (20) @(negedge Clk);

    // Reset while key 0 is mid-filter and key 3 is already pressed.
    key[3] = 1'b0;
    repeat (15) @(negedge Clk);
    key[0] = 1'b0;
    repeat (4) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    cmp("lit_rst_state", state0, 4'hF);
    cmp("lit_rst_events", press0 | rel0 | long0, 4'h0);
    Reset = 1'b0;
    repeat (10) @(negedge Clk);
    cmp("lit_rst_early", press0, 4'h0);
    @(negedge Clk);
    cmp("lit_rst_press", press0, 4'h9);
    key = 4'hF;
    repeat (20) @(negedge Clk);

    // Randomised mix of bounces, short and long holds, and rare resets.
    for (int k = 0; k < NK; k++) rem[k] = $urandom_range(1, 20);
    for (int c = 0; c < 5000; c++) begin
      for (int k = 0; k < NK; k++) begin
        if (rem[k] == 0) begin
          key[k] = ~key[k];
          rem[k] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 8) : $urandom_range(10, 90);
        end else begin
          rem[k]--;
        end
      end
      Reset = ($urandom_range(0, 599) == 0);
      @(negedge Clk);
    end
    Reset = 1'b0;
    repeat (5) @(negedge Clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
